// File: rtl/data_sram_responder_pkg.sv
// Shared types and helpers for the data SRAM responder.
// State encoding, lane count and the address-window check.
package data_sram_responder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } ds_state_t;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned NLANE = 4;

  // True when a base-relative byte offset maps to a word below 2**aw
  function automatic logic in_window(
    input logic [31:0] off,
    input int unsigned aw
  );
    logic [31:0] w_hi;
    w_hi = off >> (aw + 2);
    return (w_hi == 32'd0);
  endfunction

endpackage

// File: rtl/data_sram_responder_dsram_bank.sv
// Four byte-lane arrays with per-lane write and a registered read.
// One shared index: the caller never reads and writes in one cycle.
module data_sram_responder_dsram_bank
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        i_wen,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [31:0]       i_wdata,
  input  logic              i_rd,
  input  logic              i_rd_zero,
  output logic [31:0]       o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [31:0] w_rd;
  logic [31:0] r_rdata;

  for (genvar l = 0; l < NLANE; l++) begin : g_lane
    logic [7:0] r_arr [DEPTH];

    // Lane write: only enabled lanes take their byte of the store data
    always_ff @(posedge clk) begin
      if (i_wen[l]) begin
        r_arr[i_idx] <= i_wdata[8*l +: 8];
      end
    end

    assign w_rd[8*l +: 8] = r_arr[i_idx];
  end

  // Read register: holds until the next accepted load, 0 for misses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_rd) begin
      r_rdata <= i_rd_zero ? '0 : w_rd;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM responder: stores commit at once, loads may wait.
// Holds the wait FSM, range check, addr_err and stallreq.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic        addr_err
);

  localparam logic LP_WAIT = (WAIT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LP_CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  ds_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_aerr;

  logic [31:0]       w_off;
  logic              w_inr;
  logic [ADDR_W-1:0] w_idx;
  logic              w_load;
  logic              w_store;
  logic              w_acc_ld;
  logic              w_acc_st;
  logic [3:0]        w_wen;

  assign w_off   = data_sram_addr - BASE_ADDR;
  assign w_inr   = in_window(w_off, ADDR_W);
  assign w_idx   = w_off[ADDR_W+1:2];
  assign w_load  = data_sram_en && (data_sram_wen == 4'b0000);
  assign w_store = data_sram_en && (data_sram_wen != 4'b0000);

  // A waiting load is accepted on the edge that ends its count
  assign w_acc_ld = LP_WAIT
    ? ((r_state == ST_WAIT) && (r_cnt == '0))
    : w_load;
  assign w_acc_st = w_store && (r_state == ST_IDLE);
  assign w_wen    = (w_acc_st && w_inr) ? data_sram_wen : 4'b0000;

  assign stallreq = !rst && LP_WAIT && (
    ((r_state == ST_IDLE) && w_load) ||
    ((r_state == ST_WAIT) && (r_cnt != '0)));

  // Wait-state FSM: IDLE -> WAIT on a load, back once the count drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (LP_WAIT && w_load) begin
            r_cnt   <= LP_CNT_INIT;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // addr_err reflects the range of the most recent accepted access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aerr <= 1'b0;
    end else if (w_acc_ld || w_acc_st) begin
      r_aerr <= !w_inr;
    end
  end

  data_sram_responder_dsram_bank #(
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .i_wen     (w_wen),
    .i_idx     (w_idx),
    .i_wdata   (data_sram_wdata),
    .i_rd      (w_acc_ld),
    .i_rd_zero (!w_inr),
    .o_rdata   (data_sram_rdata)
  );

  assign addr_err = r_aerr;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed and random checks of data_sram_responder.
// Three instances cover WAIT 0/3/2 against a byte-array model.
module tb_data_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic        en    [3];
  logic [3:0]  wen   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        stall [3];
  logic        aerr  [3];

  int depth [3] = '{16, 1024, 64};
  int nwait [3] = '{0, 3, 2};

  int total = 0;
  int bad   = 0;

  logic [7:0]  mm   [3][1024][4];
  logic [31:0] e_rd [3];
  logic        e_ae [3];

  data_sram_responder #(.ADDR_W(4), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst[0]), .data_sram_en(en[0]),
    .data_sram_wen(wen[0]), .data_sram_addr(addr[0]),
    .data_sram_wdata(wdata[0]), .data_sram_rdata(rdata[0]),
    .stallreq(stall[0]), .addr_err(aerr[0]));

  data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u1 (
    .clk(clk), .rst(rst[1]), .data_sram_en(en[1]),
    .data_sram_wen(wen[1]), .data_sram_addr(addr[1]),
    .data_sram_wdata(wdata[1]), .data_sram_rdata(rdata[1]),
    .stallreq(stall[1]), .addr_err(aerr[1]));

  data_sram_responder #(.ADDR_W(6), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst(rst[2]), .data_sram_en(en[2]),
    .data_sram_wen(wen[2]), .data_sram_addr(addr[2]),
    .data_sram_wdata(wdata[2]), .data_sram_rdata(rdata[2]),
    .stallreq(stall[2]), .addr_err(aerr[2]));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mword(input int k, input int i);
    return {mm[k][i][3], mm[k][i][2], mm[k][i][1], mm[k][i][0]};
  endfunction

  // One access from a negedge; returns at the negedge after acceptance
  task automatic op(input int k, input logic [3:0] w,
                    input logic [31:0] a, input logic [31:0] d,
                    output int nst);
    logic [31:0] widx;
    bit inr;
    bit s;
    int guard;
    widx  = (a - 32'h0) / 4;
    inr   = (widx < 32'(depth[k]));
    en[k] = 1'b1; wen[k] = w; addr[k] = a; wdata[k] = d;
    nst = 0; guard = 0;
    do begin
      #1 s = stall[k];
      @(posedge clk);
      @(negedge clk);
      if (s) nst++;
      guard++;
    end while (s && guard < 40);
    en[k] = 1'b0; wen[k] = 4'b0000;
    if (w != 4'b0000) begin
      if (inr)
        for (int l = 0; l < 4; l++)
          if (w[l]) mm[k][widx][l] = d[8*l +: 8];
    end else begin
      e_rd[k] = inr ? mword(k, int'(widx)) : 32'h0;
    end
    e_ae[k] = !inr;
    chk($sformatf("stalls_u%0d", k), 32'(nst),
        (w == 4'b0000) ? 32'(nwait[k]) : 32'h0);
    chk($sformatf("rdata_u%0d", k), rdata[k], e_rd[k]);
    chk($sformatf("aerr_u%0d", k), 32'(aerr[k]), 32'(e_ae[k]));
  endtask

  initial begin
    int n;
    logic [31:0] ra;
    logic [3:0]  rw;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; en[k] = 1'b0; wen[k] = 4'b0000;
      addr[k] = 32'h0; wdata[k] = 32'h0;
      e_rd[k] = 32'h0; e_ae[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_rdata", rdata[k], 32'h0);
      chk("rst_aerr", 32'(aerr[k]), 32'h0);
      chk("rst_stall", 32'(stall[k]), 32'h0);
    end

    // WAIT=0 store then load, plus byte lanes
    op(0, 4'hF, 32'h10, 32'hDEADBEEF, n);
    op(0, 4'h0, 32'h10, 32'h0, n);
    chk("t1_rd", rdata[0], 32'hDEADBEEF);
    op(0, 4'b0010, 32'h10, 32'h0000AA00, n);
    chk("t2_store_keeps_rd", rdata[0], 32'hDEADBEEF);
    op(0, 4'h0, 32'h10, 32'h0, n);
    chk("t2_rd_a", rdata[0], 32'hDEADAAEF);
    op(0, 4'b1100, 32'h10, 32'h12340000, n);
    op(0, 4'h0, 32'h10, 32'h0, n);
    chk("t2_rd_b", rdata[0], 32'h1234AAEF);

    // Out of range on a 16-word window
    op(0, 4'hF, 32'h0, 32'h55667788, n);
    op(0, 4'h0, 32'h40, 32'h0, n);
    chk("t4_rd", rdata[0], 32'h0);
    chk("t4_aerr", 32'(aerr[0]), 32'h1);
    op(0, 4'hF, 32'h40, 32'hFFFFFFFF, n);
    chk("t4_st_aerr", 32'(aerr[0]), 32'h1);
    op(0, 4'h0, 32'h0, 32'h0, n);
    chk("t4_word0", rdata[0], 32'h55667788);
    chk("t4_aerr_clr", 32'(aerr[0]), 32'h0);

    // WAIT=3 loads, back to back
    op(1, 4'hF, 32'h10, 32'hDEADBEEF, n);
    op(1, 4'b0010, 32'h10, 32'h0000AA00, n);
    op(1, 4'b1100, 32'h10, 32'h12340000, n);
    op(1, 4'hF, 32'h20, 32'hCAFEF00D, n);
    op(1, 4'h0, 32'h10, 32'h0, n);
    chk("t3_stalls", 32'(n), 32'd3);
    chk("t3_rd", rdata[1], 32'h1234AAEF);
    op(1, 4'h0, 32'h20, 32'h0, n);
    chk("t3_stalls2", 32'(n), 32'd3);
    chk("t3_rd2", rdata[1], 32'hCAFEF00D);

    // Reset in the second wait cycle
    en[1] = 1'b1; wen[1] = 4'h0; addr[1] = 32'h10;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("t5_stall_pre", 32'(stall[1]), 32'h1);
    rst[1] = 1'b1;
    #1;
    chk("t5_stall", 32'(stall[1]), 32'h0);
    chk("t5_rdata", rdata[1], 32'h0);
    en[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    e_rd[1] = 32'h0; e_ae[1] = 1'b0;
    @(negedge clk);
    chk("t5_idle_rd", rdata[1], 32'h0);
    op(1, 4'h0, 32'h10, 32'h0, n);
    chk("t5_keep", rdata[1], 32'h1234AAEF);

    // Random mixed traffic against the byte model
    foreach (nwait[k]) begin
      if (k != 1) begin
        for (int i = 0; i < depth[k]; i++)
          op(k, 4'hF, 32'(i * 4), $urandom, n);
        for (int i = 0; i < 500; i++) begin
          ra = 32'($urandom_range(0, depth[k] * 4 + 63));
          rw = ($urandom % 2 == 0) ? 4'h0
                                   : 4'($urandom_range(1, 15));
          op(k, rw, ra, $urandom, n);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
